// File: rtl/deserializador_serial_pkg.sv
// Shared definitions for the serial deserializer: state encoding, default width
// and frame-length derivation (frame grows by one parity bit when PARITY_EN is defined).
package deserializador_serial_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int flen_calc(input int width);
`ifdef PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/deserializador_serial_contador.sv
// Loadable bit counter for the deserializer; tc flags the last bit position of a frame.
module contador_bits #(
  parameter int FLEN  = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(FLEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == TC_VAL);

endmodule

// File: rtl/deserializador_serial.sv
// MSB-first serial-to-parallel receiver with valid/ready output and sticky error flags.
// Optional even-parity bit per frame enabled by defining PARITY_EN.
module deserializador_serial
  import deserializador_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic             s_data,
  input  logic             s_first,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  output logic             parity_err,
  input  logic             clr_err
);

  localparam int FLEN  = flen_calc(WIDTH);
  localparam int CNT_W = $clog2(FLEN);

  logic [0:0]       state_q, state_d;
  logic [FLEN-2:0]  shift_q, shift_d;
  logic [FLEN-1:0]  shift_next;
  logic [WIDTH-1:0] dout_q, dout_d, word;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic             par_bad;

  logic             cnt_clr, cnt_load, cnt_inc, cnt_tc;
  logic [CNT_W-1:0] cnt;
  logic             complete, ovr_set, fe_set;

  contador_bits #(
    .FLEN  (FLEN),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (CNT_W'(1)),
    .inc      (cnt_inc),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  // The final bit never lands in the shift register; the word is formed with it in flight.
  assign shift_next = {shift_q, s_data};

`ifdef PARITY_EN
  assign word    = shift_next[FLEN-1:1];
  assign par_bad = ^shift_next;
`else
  assign word    = shift_next;
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    complete = 1'b0;
    fe_set   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_valid && s_first) begin
          shift_d    = '0;
          shift_d[0] = s_data;
          cnt_load   = 1'b1;
          state_d    = ST_RECV;
        end
      end
      ST_RECV: begin
        if (s_valid && s_first) begin
          shift_d    = '0;
          shift_d[0] = s_data;
          cnt_load   = 1'b1;
          fe_set     = 1'b1;
        end else if (s_valid) begin
          shift_d = shift_next[FLEN-2:0];
          if (cnt_tc) begin
            complete = 1'b1;
            cnt_clr  = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    ovr_set      = 1'b0;
    if (complete) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = word;
        dout_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  // Sticky flags: a set in the same cycle as clr_err takes priority.
  assign overrun_d   = (overrun_q & ~clr_err) | ovr_set;
  assign frame_err_d = (frame_err_q & ~clr_err) | fe_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef PARITY_EN
  logic parity_err_q, parity_err_d;

  assign parity_err_d = (parity_err_q & ~clr_err) | (complete & par_bad);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q == ST_RECV);
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: doc/deserializador_serial.md
# deserializador_serial

Serial-to-parallel receiver at the far end of the universal shift-register chain. It samples the bit stream shifted out of the register bank MSB-first and reassembles it into a WIDTH-bit word. It then presents the word to downstream logic on a valid/ready handshake. It sits between the shift-register output stage and any consumer of parallel words, and reports overrun and framing errors.

## Interface
- WIDTH, 8, data bits per frame; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  serial bit present this cycle.
- s_data  in  1  serial bit value.
- s_first  in  1  qualifies the first (MSB) bit of a frame; ignored unless s_valid.
- dout  out  WIDTH  assembled word.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  consumer accepts dout when high with dout_valid.
- busy  out  1  frame reception in progress.
- overrun  out  1  sticky: a completed word was dropped.
- frame_err  out  1  sticky: a frame restarted before completion.
- parity_err  out  1  sticky: parity mismatch (see Configuration).
- clr_err  in  1  synchronous clear of all sticky flags.

## Operation
- FSM has two states, IDLE and RECV. A bit counter cnt runs 0..FLEN-1. FLEN = WIDTH, or WIDTH+1 with parity.
- IDLE: s_valid&&s_first loads s_data into shift register bit 0, sets cnt=1 and goes to RECV. s_valid without s_first is ignored.
- RECV: s_valid&&!s_first shifts left with s_data entering the LSB and increments cnt. When the accepted bit is bit FLEN-1, the frame completes and the FSM returns to IDLE.
- RECV with s_valid&&s_first: the current frame is aborted and frame_err is set. The bit is taken as a new MSB (cnt=1, stay in RECV).
- Cycles with s_valid low never advance state. There is no serial-side backpressure.
- Completion with dout_valid low, or with dout_valid&&dout_ready in the same cycle: dout is loaded with the data bits and dout_valid is 1.
- Completion with dout_valid&&!dout_ready: the new word is dropped, dout is unchanged and overrun is set.
- dout_valid&&dout_ready with no completion: dout_valid clears. dout holds its value.
- busy = (state==RECV).
- clr_err clears all sticky flags. A flag set in the same cycle as clr_err wins (flag ends at 1).

## Timing
- Reset values: state IDLE, cnt 0, shift register 0, dout 0, dout_valid 0, busy 0, overrun 0, frame_err 0, parity_err 0.
- Reset asserted mid-frame discards the partial word immediately. The first frame after reset requires s_first.
- Latency: if the last frame bit is sampled at edge N, dout and dout_valid are valid after edge N.
- Minimum frame time is FLEN cycles. Back-to-back frames at one bit per cycle are sustained with no dead cycles. An s_first immediately following the last bit is accepted.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- PARITY_EN defined: each frame carries one extra even-parity bit after the LSB. On completion, parity_err is set if XOR(data bits, parity bit) = 1. The word is still delivered.
- PARITY_EN undefined: FLEN = WIDTH, and parity_err is tied to 0.

## Structure
- A shared package holds:
  - state encoding constants (IDLE, RECV),
  - the default WIDTH,
  - the FLEN derivation function.
- One sub-module, contador_bits: a loadable bit counter with clear, increment and terminal-count output (cnt==FLEN-1).

## Test plan
- WIDTH=8, send 0xA5 MSB-first with s_first on bit 7 and dout_ready=1 -> dout=0xA5 and dout_valid=1 after the 8th bit edge. Flags stay 0.
- Two back-to-back frames 0x12 then 0x34 with dout_ready=0 -> dout=0x12 held, overrun=1. Raising dout_ready clears dout_valid.
- Frame 0x34 completes in the same cycle that dout_ready=1 with 0x12 pending -> dout=0x34, dout_valid stays 1, overrun=0.
- Three bits, then s_first, then full frame 0x3C -> dout=0x3C, frame_err=1. clr_err -> frame_err=0.
- Reset asserted after 5 bits of 0xFF, released, then frame 0x81 -> dout=0x81. No stray bits from the aborted frame.
- PARITY_EN: send 0xA5 followed by parity bit 1 -> dout=0xA5, parity_err=1. With parity bit 0 -> parity_err=0.
